// File: rtl/accel_hub_pkg.sv
// accel_hub_pkg: shared types, field positions and helpers for accel_wb_hub.
// Stats offsets are only consumed when ACCEL_HUB_STATS_EN is defined.
package accel_hub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP,
    ERR
  } state_e;

  localparam int PFX_MSB = 31;
  localparam int PFX_LSB = 24;
  localparam int WIN_BIT = 23;

  localparam logic [1:0] STAT_TXN = 2'd0;
  localparam logic [1:0] STAT_ERR = 2'd1;
  localparam logic [1:0] STAT_TO  = 2'd2;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/accel_hub_stats.sv
// accel_hub_stats: saturating txn/err/timeout counters and read mux.
// Exists only when ACCEL_HUB_STATS_EN is defined.
`ifdef ACCEL_HUB_STATS_EN
module accel_hub_stats
  import accel_hub_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_txn_i,
  input  logic        inc_err_i,
  input  logic        inc_to_i,
  input  logic        clr_i,
  input  logic [1:0]  off_i,
  output logic [31:0] rd_o
);
  logic [31:0] txn_q, txn_d;
  logic [31:0] err_q, err_d;
  logic [31:0] to_q, to_d;

  // next counter values: clear wins, otherwise saturating increments
  always_comb begin
    txn_d = txn_q;
    err_d = err_q;
    to_d  = to_q;
    if (clr_i) begin
      txn_d = '0;
      err_d = '0;
      to_d  = '0;
    end else begin
      if (inc_txn_i) txn_d = sat_inc(txn_q);
      if (inc_err_i) err_d = sat_inc(err_q);
      if (inc_to_i)  to_d  = sat_inc(to_q);
    end
  end

  // counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txn_q <= '0;
      err_q <= '0;
      to_q  <= '0;
    end else begin
      txn_q <= txn_d;
      err_q <= err_d;
      to_q  <= to_d;
    end
  end

  // read mux by word offset; offset 3 reads zero
  always_comb begin
    rd_o = '0;
    unique case (off_i)
      STAT_TXN: rd_o = txn_q;
      STAT_ERR: rd_o = err_q;
      STAT_TO:  rd_o = to_q;
      default:  rd_o = '0;
    endcase
  end

endmodule
`endif

// File: rtl/accel_wb_hub.sv
// accel_wb_hub: one upstream Wishbone master decoded onto NR_ACCEL slaves
// with timeout/error responses; ACCEL_HUB_STATS_EN adds a counter window.
module accel_wb_hub
  import accel_hub_pkg::*;
#(
  parameter int         NR_ACCEL    = 4,
  parameter logic [7:0] BASE_PREFIX = 8'hE0,
  parameter int         SLOT_LSB    = 12,
  parameter int         TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst_sys,
  input  logic [31:0]            us_adr_i,
  input  logic [31:0]            us_dat_i,
  input  logic [3:0]             us_sel_i,
  input  logic                   us_cyc_i,
  input  logic                   us_stb_i,
  input  logic                   us_we_i,
  output logic [31:0]            us_dat_o,
  output logic                   us_ack_o,
  output logic                   us_err_o,
  output logic [31:0]            ds_adr_o,
  output logic [31:0]            ds_dat_o,
  output logic [3:0]             ds_sel_o,
  output logic                   ds_we_o,
  output logic [NR_ACCEL-1:0]    ds_cyc_o,
  output logic [NR_ACCEL-1:0]    ds_stb_o,
  input  logic [32*NR_ACCEL-1:0] ds_dat_i,
  input  logic [NR_ACCEL-1:0]    ds_ack_i,
  input  logic [NR_ACCEL-1:0]    ds_err_i,
  input  logic [NR_ACCEL-1:0]    accel_irq_i,
  output logic                   irq_o
);
  localparam int IDX_W = idx_w(NR_ACCEL);
  localparam logic [IDX_W:0] NR_L = (IDX_W+1)'(NR_ACCEL);
  localparam logic [NR_ACCEL-1:0] ONE = NR_ACCEL'(1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [31:0]       adr_q, dat_q;
  logic [3:0]        sel_q;
  logic              we_q, win_q;
  logic [IDX_W-1:0]  slot_q;
  logic [15:0]       cnt_q;

  logic [31:0]          us_dat_q, us_dat_d;
  logic                 us_ack_q, us_ack_d;
  logic                 us_err_q, us_err_d;
  logic [NR_ACCEL-1:0]  ds_stb_q, ds_stb_d;
  logic                 irq_q;

  logic              req, pfx_ok, hit, win_hit;
  logic [IDX_W-1:0]  slot_in;
  logic              sel_ack, sel_err, to_hit;
  logic [31:0]       slot_word, stat_rd;
  logic              st_txn, st_err, st_to, st_clr;

  assign req     = us_cyc_i & us_stb_i;
  assign pfx_ok  = us_adr_i[PFX_MSB:PFX_LSB] == BASE_PREFIX;
  assign slot_in = us_adr_i[SLOT_LSB +: IDX_W];
  assign hit     = pfx_ok & ~us_adr_i[WIN_BIT]
                 & ({1'b0, slot_in} < NR_L);

  assign sel_ack   = ds_ack_i[slot_q];
  assign sel_err   = ds_err_i[slot_q];
  assign to_hit    = cnt_q == TO_LAST;
  assign slot_word = ds_dat_i[{slot_q, 5'd0} +: 32];

`ifdef ACCEL_HUB_STATS_EN
  assign win_hit = pfx_ok & us_adr_i[WIN_BIT];

  accel_hub_stats u_stats (
    .clk_i     (clk),
    .rst_i     (rst_sys),
    .inc_txn_i (st_txn),
    .inc_err_i (st_err),
    .inc_to_i  (st_to),
    .clr_i     (st_clr),
    .off_i     (adr_q[3:2]),
    .rd_o      (stat_rd)
  );
`else
  logic unused_stats;
  assign win_hit      = 1'b0;
  assign stat_rd      = '0;
  assign unused_stats = ^{st_txn, st_err, st_to, st_clr};
`endif

  // state register
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next state: abort beats any response, responses beat the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (req) state_d = (hit || win_hit) ? ACTIVE : ERR;
      ACTIVE:
        if (!us_cyc_i) state_d = IDLE;
        else if (win_q || sel_err || sel_ack || to_hit)
          state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs plus stats event pulses
  always_comb begin
    us_ack_d = 1'b0;
    us_err_d = 1'b0;
    us_dat_d = '0;
    ds_stb_d = '0;
    st_txn   = 1'b0;
    st_err   = 1'b0;
    st_to    = 1'b0;
    st_clr   = 1'b0;
    unique case (state_q)
      IDLE:
        if (req) begin
          if (hit) begin
            ds_stb_d = ONE << slot_in;
          end else if (!win_hit) begin
            us_err_d = 1'b1;
            st_err   = 1'b1;
          end
        end
      ACTIVE:
        if (us_cyc_i) begin
          if (win_q) begin
            us_ack_d = 1'b1;
            us_dat_d = we_q ? '0 : stat_rd;
            st_clr   = we_q;
          end else if (sel_err) begin
            us_err_d = 1'b1;
            st_err   = 1'b1;
          end else if (sel_ack) begin
            us_ack_d = 1'b1;
            us_dat_d = we_q ? '0 : slot_word;
            st_txn   = 1'b1;
          end else if (to_hit) begin
            us_err_d = 1'b1;
            st_err   = 1'b1;
            st_to    = 1'b1;
          end else begin
            ds_stb_d = ds_stb_q;
          end
        end
      default: ;
    endcase
  end

  // request latch, timeout counter and output registers
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      win_q    <= 1'b0;
      slot_q   <= '0;
      cnt_q    <= '0;
      us_dat_q <= '0;
      us_ack_q <= 1'b0;
      us_err_q <= 1'b0;
      ds_stb_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      us_dat_q <= us_dat_d;
      us_ack_q <= us_ack_d;
      us_err_q <= us_err_d;
      ds_stb_q <= ds_stb_d;
      irq_q    <= |accel_irq_i;
      if (state_q == IDLE && req && (hit || win_hit)) begin
        adr_q  <= us_adr_i;
        dat_q  <= us_dat_i;
        sel_q  <= us_sel_i;
        we_q   <= us_we_i;
        win_q  <= win_hit;
        slot_q <= slot_in;
        cnt_q  <= '0;
      end else if (state_q == ACTIVE) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign us_dat_o = us_dat_q;
  assign us_ack_o = us_ack_q;
  assign us_err_o = us_err_q;
  assign ds_adr_o = adr_q;
  assign ds_dat_o = dat_q;
  assign ds_sel_o = sel_q;
  assign ds_we_o  = we_q;
  assign ds_cyc_o = ds_stb_q;
  assign ds_stb_o = ds_stb_q;
  assign irq_o    = irq_q;

endmodule
